cube_seq_ctrl: RTL and testbench

CUBE_SEQ_CTRL -- requirements
Module: cube_seq_ctrl

---
 rtl/cube_seq_ctrl_pkg.sv | 13 +
 rtl/cube_mul.sv | 16 +
 rtl/cube_seq_ctrl.sv | 113 +++++++++++
 tb/tb_cube_seq_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cube_seq_ctrl_pkg.sv
// Shared definitions for the cube sequencer: state encoding and default operand width.
package cube_seq_ctrl_pkg;

  localparam int unsigned W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cube_mul.sv
// Shared combinational multiplier: 2W-bit by W-bit unsigned product, 3W bits wide.
module cube_mul
  import cube_seq_ctrl_pkg::*;
#(
  parameter int W = W_DEFAULT,
  localparam int RW = 3 * W
) (
  input  logic [2*W-1:0] a_i,
  input  logic [W-1:0]   b_i,
  output logic [RW-1:0]  prod_o
);

  // Result width equals the sum of operand widths, so no bits are lost.
  assign prod_o = a_i * b_i;

endmodule

// File: rtl/cube_seq_ctrl.sv
// Computes the unsigned cube of an operand in two passes through one shared multiplier.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; in_ready is high only in IDLE, out_valid only in DONE, and out_data holds steady while out_valid waits for out_ready.
module cube_seq_ctrl
  import cube_seq_ctrl_pkg::*;
#(
  parameter int W = W_DEFAULT,
  localparam int RW = 3 * W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [RW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic [7:0]    ops_count,
  output logic [1:0]    dbg_state
);

  state_e            state_q;
  logic [W-1:0]      operand_q;
  logic [2*W-1:0]    square_q;
  logic [RW-1:0]     result_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [7:0]        ops_q;

  logic [2*W-1:0]    mul_a_d;
  logic [W-1:0]      mul_b_d;
  logic [RW-1:0]     mul_prod;

  // Operand mux: idle states feed zeros so the multiplier does not toggle.
  always_comb begin
    mul_a_d = '0;
    mul_b_d = '0;
    case (state_q)
      MUL1: begin
        mul_a_d = {{W{1'b0}}, operand_q};
        mul_b_d = operand_q;
      end
      MUL2: begin
        mul_a_d = square_q;
        mul_b_d = operand_q;
      end
      default: begin
        mul_a_d = '0;
        mul_b_d = '0;
      end
    endcase
  end

  cube_mul #(.W(W)) u_mul (
    .a_i    (mul_a_d),
    .b_i    (mul_b_d),
    .prod_o (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      operand_q   <= '0;
      square_q    <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ops_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            operand_q  <= in_data;
            state_q    <= MUL1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        MUL1: begin
          square_q <= mul_prod[2*W-1:0];
          state_q  <= MUL2;
        end
        MUL2: begin
          result_q    <= mul_prod;
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            ops_q       <= ops_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = result_q;
  assign busy      = busy_q;
  assign ops_count = ops_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cube_seq_ctrl.sv
// Self-checking bench for cube_seq_ctrl against a timeline model of the cube sequencer.
module tb_cube_seq_ctrl;

  localparam int W  = 4;
  localparam int RW = 3 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [RW-1:0] out_data;
  logic          busy;
  logic [7:0]    ops_count;
  logic [1:0]    dbg_state;

  cube_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .ops_count (ops_count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One operation occupies the block from its accepting edge until the output handshake;
  // the cube becomes visible two edges after acceptance.
  logic [RW-1:0] exp_q[$];
  int cyc = 0;
  bit m_busy = 1'b0;
  int m_acc = 0;
  int m_ops = 0;
  int m_done_total = 0;

  always @(posedge clk) begin
    bit ov;
    int v;
    ov = m_busy && (cyc - m_acc >= 2);
    cyc++;
    if (rst) begin
      m_busy = 1'b0;
      m_ops  = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_acc  = cyc;
        v = int'(in_data);
        exp_q.push_back(RW'(v * v * v));
      end
    end else if (ov && out_ready) begin
      m_busy = 1'b0;
      m_ops  = (m_ops + 1) % 256;
      m_done_total++;
      void'(exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    bit ov;
    int d;
    logic [1:0] es;
    if (cyc > 0) begin
      d  = cyc - m_acc;
      ov = m_busy && (d >= 2);
      es = !m_busy ? 2'd0 : (d == 0) ? 2'd1 : (d == 1) ? 2'd2 : 2'd3;
      check("in_ready", in_ready, !m_busy);
      check("out_valid", out_valid, ov);
      check("busy", busy, m_busy);
      check("ops_count", ops_count, m_ops);
      check("state", dbg_state, es);
      if (ov) check("out_data", out_data, exp_q[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (m_busy && m_acc == cyc) ok = 1'b1;
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input bit rand_ready);
    int i;
    i = 0;
    while (m_busy && i < 100) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      in_data = W'($urandom);
      step();
      i++;
    end
    if (m_busy) check("idle_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] vals[3];
    int vc, first, k;
    logic [RW-1:0] seen;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ops", ops_count, 0);
    step();

    // Reset while the second multiply pass is pending.
    out_ready = 1'b0;
    send(4'd7);
    step();
    check("mul2_state", dbg_state, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_state", dbg_state, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_ops", ops_count, 0);
    check("abort_data", out_data, 0);
    repeat (4) step();

    // 3 -> 27, one-cycle valid with out_ready held high.
    out_ready = 1'b1;
    send(4'd3);
    vc = 0; first = -1; seen = '0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (out_valid) begin
        vc++;
        seen = out_data;
        if (first < 0) first = i;
      end
    end
    check("t3_valid_cycles", vc, 1);
    check("t3_latency", first, 2);
    check("t3_data", seen, 27);
    check("t3_ops", ops_count, 1);

    // 15 -> 3375 held under backpressure.
    out_ready = 1'b0;
    send(4'd15);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("t15_valid_hold", out_valid, 1);
      check("t15_data_hold", out_data, 3375);
      in_data = W'($urandom);
      step();
    end
    out_ready = 1'b1;
    step();
    check("t15_release", out_valid, 0);
    check("t15_ops", ops_count, 2);

    // Back-to-back 0,1,2 with in_valid held and in_data scrambled while busy.
    vals[0] = 4'd0; vals[1] = 4'd1; vals[2] = 4'd2;
    k = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && k < 3; i++) begin
      in_data = (m_busy || k >= 3) ? W'($urandom) : vals[k];
      step();
      if (m_busy && m_acc == cyc) k++;
    end
    in_valid = 1'b0;
    check("b2b_accepted", k, 3);
    wait_idle(1'b0);
    check("b2b_ops", ops_count, 5);

    // Random traffic, long enough to wrap ops_count.
    for (int n = 0; n < 300; n++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
      end
      send(W'($urandom));
      in_valid = 1'($urandom_range(0, 1));
      wait_idle(1'b1);
      in_valid = 1'b0;
      if (m_done_total == 256) check("ops_wrap", ops_count, 0);
    end
    step();
    check("final_ops", ops_count, m_done_total % 256);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
